// File: rtl/div_unit_pkg.sv
// div_unit_pkg: state encodings and alucontrol codes shared by the divider and decoder.
// No ports; imported by div_unit and the decoder.
package div_unit_pkg;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_ON   = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;
  // Placed next to the MULT/MULTU codes; the decoder derives start and signed_div from these.
  localparam logic [3:0] MULT_CONTROL  = 4'b1000;
  localparam logic [3:0] MULTU_CONTROL = 4'b1001;
  localparam logic [3:0] DIV_CONTROL   = 4'b1010;
  localparam logic [3:0] DIVU_CONTROL  = 4'b1011;
endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring DIV/DIVU engine, one quotient bit per clock.
// Ports: clk, resetn (async active-low), start, signed_div, annul, a (rs), b (rt),
//        result {hi=remainder, lo=quotient} registered, ready (1-cycle pulse), stall.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                signed_div,
  input  logic                annul,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] result,
  output logic                ready,
  output logic                stall
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic sdiv_q, sdiv_d, negq_q, negq_d, negr_q, negr_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic ready_q, ready_d;
  logic [DATA_W:0] trial;
  // Full-width shifted partial remainder so divisors above 2**(DATA_W-1) compare correctly.
  assign trial = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dvs_q};
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    sdiv_d   = sdiv_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = 1'b0;
    unique case (state_q)
      DIV_IDLE: if (start) begin
        sdiv_d  = signed_div;
        negq_d  = a[DATA_W-1] ^ b[DATA_W-1];
        negr_d  = a[DATA_W-1];
        // Divide by zero keeps the raw dividend for the fixed remainder.
        dvd_d   = (b == '0) ? a : ((signed_div & a[DATA_W-1]) ? -a : a);
        dvs_d   = (signed_div & b[DATA_W-1]) ? -b : b;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = (b == '0) ? DIV_ZERO : DIV_ON;
      end
      DIV_ZERO: begin
        result_d = {dvd_q, {DATA_W{1'b1}}};
        ready_d  = 1'b1;
        state_d  = DIV_DONE;
      end
      DIV_ON: begin
        rem_d = trial[DATA_W] ? {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]} : trial[DATA_W-1:0];
        dvd_d = {dvd_q[DATA_W-2:0], ~trial[DATA_W]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          result_d = {(sdiv_q & negr_q) ? -rem_d : rem_d, (sdiv_q & negq_q) ? -dvd_d : dvd_d};
          ready_d  = 1'b1;
          state_d  = DIV_DONE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
    if (annul) begin
      state_d  = DIV_IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sdiv_q   <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      sdiv_q   <= sdiv_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end
  assign result = result_q;
  assign ready  = ready_q;
  assign stall  = start & ~ready_q & ~annul;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit against a transaction-level divide model.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [63:0] result;
  logic        ready;
  logic        stall;
  int tests = 0;
  int fails = 0;
  bit          busy = 0;
  bit          exp_ready = 0;
  int          left = 0;
  logic [63:0] exp_res = '0;
  logic [63:0] held = '0;

  div_unit #(.DATA_W(32), .CNT_W(5)) dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div), .annul(annul),
    .a(a), .b(b), .result(result), .ready(ready), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input bit s);
    longint sx, sy, q, r;
    if (y == 0) return {x, 32'hFFFFFFFF};
    if (!s) return {x % y, x / y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h at %0t", nm, got, want, $time);
    end
  endtask

  // One clock: advance the model over the rising edge, then compare at the falling edge.
  task automatic step();
    @(posedge clk);
    if (resetn) begin
      if (annul) begin
        busy = 0;
        exp_ready = 0;
      end else if (exp_ready) exp_ready = 0;
      else if (busy) begin
        left--;
        if (left == 0) begin
          busy = 0;
          exp_ready = 1;
          held = exp_res;
        end
      end else if (start) begin
        busy = 1;
        left = (b == 0) ? 1 : 32;
        exp_res = model(a, b, signed_div);
      end
    end
    @(negedge clk);
    if (resetn) begin
      check("stall", 64'(stall), 64'(start & ~exp_ready & ~annul));
      check("ready", 64'(ready), 64'(exp_ready));
      check("result", result, held);
    end
  endtask

  task automatic run(input logic [31:0] x, input logic [31:0] y, input bit s,
                     input logic [63:0] want, input int want_n, input string nm);
    int n = 0;
    int stalls = 0;
    bit got = 0;
    check({nm, "_model"}, model(x, y, s), want);
    a = x;
    b = y;
    signed_div = s;
    start = 1'b1;
    #1 stalls += int'(stall);
    for (int i = 1; i <= 60 && !got; i++) begin
      step();
      n = i;
      if (i == 1) begin
        a = ~x;
        b = y ^ 32'h5A5A0001;
        signed_div = ~s;
      end
      if (ready) begin
        got = 1;
        check({nm, "_result"}, result, want);
      end else stalls += int'(stall);
    end
    if (!got) check({nm, "_timeout"}, 64'(got), 64'd1);
    check({nm, "_latency"}, 64'(n), 64'(want_n));
    check({nm, "_stalls"}, 64'(stalls), 64'(want_n));
    step();
    start = 1'b0;
  endtask

  initial begin
    #1;
    check("reset_result", result, 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    run(32'd100, 32'd7, 0, 64'h00000002_0000000E, 33, "divu_100_7");
    run(32'hFFFFFFF9, 32'd2, 1, 64'hFFFFFFFF_FFFFFFFD, 33, "div_m7_2");
    run(32'd7, 32'hFFFFFFFE, 1, 64'h00000001_FFFFFFFD, 33, "div_7_m2");
    run(32'h80000000, 32'hFFFFFFFF, 1, 64'h00000000_80000000, 33, "div_ovf");
    run(32'h12345678, 32'd0, 0, 64'h12345678_FFFFFFFF, 2, "divu_zero");
    run(32'hFFFFFFF9, 32'd0, 1, 64'hFFFFFFF9_FFFFFFFF, 2, "div_zero");
    run(32'hFFFFFFFF, 32'h80000001, 0, 64'h7FFFFFFE_00000001, 33, "divu_big");
    run(32'h80000000, 32'd7, 1, 64'hFFFFFFFE_EDB6DB6E, 33, "div_min_7");
    a = 32'd100;
    b = 32'd7;
    signed_div = 1'b0;
    start = 1'b1;
    repeat (11) step();
    annul = 1'b1;
    #1 check("annul_stall", 64'(stall), 64'd0);
    step();
    annul = 1'b0;
    start = 1'b0;
    repeat (40) step();
    check("annul_hold", result, 64'hFFFFFFFE_EDB6DB6E);
    run(32'd9, 32'd3, 0, 64'h00000000_00000003, 33, "divu_9_3");
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    repeat (21) step();
    #2 resetn = 1'b0;
    #1;
    check("midreset_result", result, 64'd0);
    check("midreset_ready", 64'(ready), 64'd0);
    busy = 0;
    exp_ready = 0;
    held = '0;
    start = 1'b0;
    step();
    resetn = 1'b1;
    run(32'd1, 32'd1, 0, 64'h00000000_00000001, 33, "divu_1_1");
    repeat (40) step();
    check("no_restart", result, 64'h00000000_00000001);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
